// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word per pc, holds it for decode,
// then steps, branches or halts on acceptance.
`ifndef InstrWidth
`define InstrWidth 16
`endif

module fetch_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = `InstrWidth
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   halted,
  input  logic                   branch_en,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   fetch_halted
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE =
    {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0] state;

  // pc is a flop, so the address is registered for free
  assign mem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= '0;
      mem_req      <= 1'b0;
      instr        <= '0;
      instr_valid  <= 1'b0;
      fetch_halted <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state   <= FETCH;
          mem_req <= 1'b1;
        end
        FETCH: begin
          if (mem_ack) begin
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
            state       <= VALID;
          end
        end
        VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            // halt wins over a simultaneous branch
            if (halted) begin
              state        <= HALT;
              fetch_halted <= 1'b1;
            end else begin
              pc      <= branch_en ? branch_target : pc + PC_ONE;
              mem_req <= 1'b1;
              state   <= FETCH;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations
// plus randomized traffic compared each cycle against a flag-based model.
`timescale 1ns/1ps

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;
  logic        branch_en;
  logic [15:0] branch_target;
  logic [15:0] pc;
  logic        fetch_halted;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic        chk_en  = 1'b0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .halted        (halted),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .pc            (pc),
    .fetch_halted  (fetch_halted)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
  endtask

  // Behavioural model: a few flags describing what the unit is doing
  logic        m_started = 1'b0;
  logic        m_wait    = 1'b0;
  logic        m_have    = 1'b0;
  logic        m_halt    = 1'b0;
  logic [15:0] m_pc      = '0;
  logic [15:0] m_instr   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started <= 1'b0;
      m_wait    <= 1'b0;
      m_have    <= 1'b0;
      m_halt    <= 1'b0;
      m_pc      <= '0;
      m_instr   <= '0;
    end else if (!m_started) begin
      m_started <= 1'b1;
      m_wait    <= 1'b1;
    end else if (m_wait) begin
      if (mem_ack) begin
        m_instr <= mem_rdata;
        m_have  <= 1'b1;
        m_wait  <= 1'b0;
      end
    end else if (m_have && instr_ready) begin
      m_have <= 1'b0;
      if (halted) m_halt <= 1'b1;
      else begin
        m_pc   <= branch_en ? branch_target : 16'(m_pc + 16'd1);
        m_wait <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.mem_req", 32'(mem_req), 32'(m_wait));
      chk("m.mem_addr", 32'(mem_addr), 32'(m_pc));
      chk("m.pc", 32'(pc), 32'(m_pc));
      chk("m.instr", 32'(instr), 32'(m_instr));
      chk("m.instr_valid", 32'(instr_valid), 32'(m_have));
      chk("m.fetch_halted", 32'(fetch_halted), 32'(m_halt));
    end
  end

  task automatic idle_in();
    mem_ack       = 1'b0;
    mem_rdata     = '0;
    instr_ready   = 1'b0;
    halted        = 1'b0;
    branch_en     = 1'b0;
    branch_target = '0;
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  // present an ack for one cycle while in FETCH
  task automatic ack_word(input logic [15:0] d);
    mem_ack   = 1'b1;
    mem_rdata = d;
    nclk();
    mem_ack   = 1'b0;
  endtask

  task automatic accept(input logic h, input logic b,
                        input logic [15:0] t);
    instr_ready   = 1'b1;
    halted        = h;
    branch_en     = b;
    branch_target = t;
    nclk();
    idle_in();
  endtask

  initial begin
    rst_n = 1'b1;
    idle_in();
    #1 rst_n = 1'b0;
    nclk();
    nclk();
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.instr_valid", 32'(instr_valid), 32'd0);
    chk("rst.pc", 32'(pc), 32'd0);
    chk("rst.instr", 32'(instr), 32'd0);
    chk("rst.fetch_halted", 32'(fetch_halted), 32'd0);
    chk_en = 1'b1;

    // first fetch with two wait states
    rst_n = 1'b1;
    nclk();
    chk("w1.req", 32'(mem_req), 32'd1);
    chk("w1.addr", 32'(mem_addr), 32'd0);
    nclk();
    chk("w2.addr", 32'(mem_addr), 32'd0);
    nclk();
    chk("w3.addr", 32'(mem_addr), 32'd0);
    ack_word(16'h1234);
    chk("f0.instr", 32'(instr), 32'h1234);
    chk("f0.valid", 32'(instr_valid), 32'd1);
    chk("f0.req", 32'(mem_req), 32'd0);

    // hold while not ready, with stray acks ignored
    for (int i = 0; i < 3; i++) begin
      mem_ack   = i[0];
      mem_rdata = 16'hDEAD;
      nclk();
      chk("hold.instr", 32'(instr), 32'h1234);
      chk("hold.pc", 32'(pc), 32'd0);
      chk("hold.valid", 32'(instr_valid), 32'd1);
      chk("hold.req", 32'(mem_req), 32'd0);
    end
    idle_in();
    accept(1'b0, 1'b0, 16'h0);
    chk("step.pc", 32'(pc), 32'd1);
    chk("step.req", 32'(mem_req), 32'd1);

    // branch to 0x0040
    ack_word(16'h5555);
    accept(1'b0, 1'b1, 16'h0040);
    chk("br.addr", 32'(mem_addr), 32'h0040);
    chk("br.req", 32'(mem_req), 32'd1);

    // branch to the top, then wrap
    ack_word(16'h0101);
    accept(1'b0, 1'b1, 16'hFFFF);
    chk("top.addr", 32'(mem_addr), 32'hFFFF);
    ack_word(16'h0202);
    accept(1'b0, 1'b0, 16'h0);
    chk("wrap.addr", 32'(mem_addr), 32'h0000);
    chk("wrap.req", 32'(mem_req), 32'd1);

    // halt beats a simultaneous branch
    ack_word(16'hF000);
    accept(1'b1, 1'b1, 16'h0040);
    chk("halt.fh", 32'(fetch_halted), 32'd1);
    chk("halt.req", 32'(mem_req), 32'd0);
    chk("halt.pc", 32'(pc), 32'd0);
    for (int i = 0; i < 20; i++) begin
      mem_ack     = ~mem_ack;
      mem_rdata   = 16'(i);
      instr_ready = 1'b1;
      branch_en   = 1'b1;
      nclk();
      if (i == 19) begin
        chk("halt20.fh", 32'(fetch_halted), 32'd1);
        chk("halt20.req", 32'(mem_req), 32'd0);
        chk("halt20.instr", 32'(instr), 32'hF000);
      end
    end
    idle_in();

    // asynchronous reset in the middle of a fetch
    rst_n = 1'b0;
    nclk();
    rst_n = 1'b1;
    nclk();
    chk("rf.req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    #1;
    chk("ar.req", 32'(mem_req), 32'd0);
    chk("ar.valid", 32'(instr_valid), 32'd0);
    nclk();
    nclk();
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    nclk();
    chk("ar.addr", 32'(mem_addr), 32'd0);
    chk("ar.req2", 32'(mem_req), 32'd1);
    chk("ar.instr", 32'(instr), 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else if (m_halt && $urandom_range(0, 9) == 0) rst_n = 1'b0;
      mem_ack       = ($urandom_range(0, 2) == 0);
      mem_rdata     = 16'($urandom);
      instr_ready   = ($urandom_range(0, 1) == 0);
      halted        = ($urandom_range(0, 39) == 0);
      branch_en     = ($urandom_range(0, 3) == 0);
      branch_target = ($urandom_range(0, 7) == 0) ? 16'hFFFF
                                                  : 16'($urandom);
      nclk();
    end
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
